// File: rtl/store_byte_writer_pkg.sv
// Shared constants, types and helpers for the 2 KB byte-addressable store path.
// Consumed by byte_ram_2k and store_byte_writer.
package mem_pkg;

   localparam int unsigned MEM_BYTES = 2048;
   localparam int unsigned ADDR_W    = $clog2(MEM_BYTES);

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      DONE
   } wr_state_e;

   // The reserved size code behaves as a word store.
   function automatic logic [2:0] size_to_nbytes(input size_e size);
      case (size)
         SZ_BYTE: return 3'd1;
         SZ_HALF: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
      case (size)
         SZ_BYTE: return 1'b0;
         SZ_HALF: return lo[0];
         default: return (lo != 2'b00);
      endcase
   endfunction

   // Byte address plus small offset, modulo the RAM depth.
   function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] base,
                                                  input logic [2:0]        ofs,
                                                  input int unsigned       depth);
      logic [ADDR_W:0] sum;
      sum = {1'b0, base} + {{(ADDR_W-2){1'b0}}, ofs};
      if (sum >= (ADDR_W+1)'(depth)) begin
         sum = sum - (ADDR_W+1)'(depth);
      end
      return sum[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/store_byte_writer_ram.sv
// byte_ram_2k: byte array with one synchronous byte write port and a
// combinational big-endian 4-byte read that wraps at the end of the array.
module byte_ram_2k
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = mem_pkg::MEM_BYTES,
  parameter              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wbyte,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wbyte;
    end
  end

  assign rd_data = {mem[rd_addr],
                    mem[wrap_add(rd_addr, 3'd1, MEM_BYTES)],
                    mem[wrap_add(rd_addr, 3'd2, MEM_BYTES)],
                    mem[wrap_add(rd_addr, 3'd3, MEM_BYTES)]};

endmodule

// File: rtl/store_byte_writer.sv
// store_byte_writer: accepts byte/half/word stores and commits them MSB-first,
// one byte per cycle, into byte_ram_2k. Define MISALIGN_TRAP_EN to trap misaligned stores.
module store_byte_writer
   import mem_pkg::*;
#(
   parameter int unsigned MEM_BYTES = mem_pkg::MEM_BYTES,
   parameter              INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [1:0]        req_size,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [31:0]       rd_data
);

   wr_state_e         state;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [2:0]        nbytes_q;
   logic [2:0]        cnt_q;

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [7:0]        wbyte;
   logic [1:0]        lane;

   // lane counts down from the MSB of the stored field to byte 0.
   always_comb begin
      we    = (state == WRITE);
      waddr = wrap_add(addr_q, cnt_q, MEM_BYTES);
      lane  = 2'(nbytes_q - cnt_q - 3'd1);
      case (lane)
         2'd0:    wbyte = wdata_q[7:0];
         2'd1:    wbyte = wdata_q[15:8];
         2'd2:    wbyte = wdata_q[23:16];
         default: wbyte = wdata_q[31:24];
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         err       <= 1'b0;
`endif
         addr_q    <= '0;
         wdata_q   <= '0;
         nbytes_q  <= '0;
         cnt_q     <= '0;
      end else begin
         done <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         err  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  nbytes_q  <= size_to_nbytes(size_e'(req_size));
                  cnt_q     <= '0;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                  // Misaligned stores bypass WRITE entirely: no RAM byte changes.
                  if (is_misaligned(size_e'(req_size), req_addr[1:0])) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state <= WRITE;
                  end
`else
                  state <= WRITE;
`endif
               end
            end
            WRITE: begin
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == nbytes_q - 3'd1) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

`ifndef MISALIGN_TRAP_EN
   assign err = 1'b0;
`endif

   byte_ram_2k #(
      .MEM_BYTES (MEM_BYTES),
      .INIT_FILE (INIT_FILE)
   ) u_ram (
      .clk     (clk),
      .we      (we),
      .waddr   (waddr),
      .wbyte   (wbyte),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_store_byte_writer.sv
// Bench for store_byte_writer: byte-level memory model with a countdown of
// busy cycles per accepted store, checked every cycle, plus literal expectations.
module tb_store_byte_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [10:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic        busy, done, err;
   logic [10:0] rd_addr = '0;
   logic [31:0] rd_data;

   always #5 clk = ~clk;

   store_byte_writer #(
      .MEM_BYTES (2048),
      .INIT_FILE ("")
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_size  (req_size),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit chk_en   = 1'b0;
   bit rand_rd  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_bound(input string name);
      n_checks++;
      $display("FAIL %s: got no response expected response within bound", name);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int         a;
      logic [7:0] d;
   } wr_t;

   logic [7:0] mm [2048];
   bit         known [2048];
   wr_t        wq [$];
   wr_t        m_w;
   int         phase = 0;   // cycles left before the writer is ready again
   bit         cur_trap = 1'b0;
   int         m_n;

   function automatic int nbytes_of(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit misaligned(input logic [1:0] s, input logic [10:0] a);
      return (s == 2'd1 && a[0]) || (s >= 2'd2 && a[1:0] != 2'b00);
   endfunction

   function automatic bit trap_of(input logic [1:0] s, input logic [10:0] a);
`ifdef MISALIGN_TRAP_EN
      return misaligned(s, a);
`else
      return (s == 2'd3 && a == 11'h7FF && 1'b0);
`endif
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase    = 0;
         cur_trap = 1'b0;
         wq.delete();
      end else if (phase > 0) begin
         if (wq.size() > 0) begin
            m_w = wq.pop_front();
            mm[m_w.a]    = m_w.d;
            known[m_w.a] = 1'b1;
         end
         phase--;
      end else if (req_valid) begin
         m_n      = nbytes_of(req_size);
         cur_trap = trap_of(req_size, req_addr);
         if (cur_trap) begin
            phase = 1;
         end else begin
            for (int i = 0; i < m_n; i++) begin
               m_w.a = (int'(req_addr) + i) % 2048;
               m_w.d = 8'(req_wdata >> (8 * (m_n - 1 - i)));
               wq.push_back(m_w);
            end
            phase = m_n + 1;
         end
      end
   end

   function automatic bit model_known(input int a);
      return known[a % 2048] && known[(a + 1) % 2048] && known[(a + 2) % 2048] && known[(a + 3) % 2048];
   endfunction

   function automatic logic [31:0] model_rd(input int a);
      return {mm[a % 2048], mm[(a + 1) % 2048], mm[(a + 2) % 2048], mm[(a + 3) % 2048]};
   endfunction

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #2;
      if (rand_rd) rd_addr = 11'($urandom);
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("req_ready", 32'(req_ready), 32'(phase == 0));
         check("busy", 32'(busy), 32'(phase > 0));
         check("done", 32'(done), 32'(phase == 1));
         check("err", 32'(err), 32'(phase == 1 && cur_trap));
         if (model_known(int'(rd_addr))) check("rd_data", rd_data, model_rd(int'(rd_addr)));
      end
   end

   // ---------------- stimulus ----------------
   task automatic store(input logic [10:0] a, input logic [31:0] d, input logic [1:0] s,
                        input bit hold, input bit wait_done, output int acc, output int lat);
      int g;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
      req_wdata = d;
      req_size  = s;
      g = 0;
      while (!req_ready && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) fail_bound("accept_timeout");
      acc = cyc + 1;
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      lat = 0;
      if (wait_done) begin
         lat = 1;
         while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
         end
         if (lat >= 30) fail_bound("done_timeout");
      end
   endtask

   task automatic rd_check(input string name, input logic [10:0] a, input logic [31:0] exp);
      @(negedge clk);
      #2 rd_addr = a;
      #1 check(name, rd_data, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc1, acc2, acc3, lat, exp_lat;
      logic [10:0] a;
      logic [31:0] d;
      logic [1:0]  s;

      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      #2 rst_n = 1'b1;

      // Fill the whole RAM so every read has a defined expectation.
      for (int i = 0; i < 512; i++) begin
         store(11'(i * 4), $urandom, 2'd2, 1'b0, 1'b1, acc1, lat);
      end

      // Word store
      store(11'h010, 32'hDEADBEEF, 2'd2, 1'b0, 1'b1, acc1, lat);
      check("word_latency", lat, 32'd5);
      rd_check("word_rd", 11'h010, 32'hDEADBEEF);

      // Byte then half
      store(11'h020, 32'h55667788, 2'd2, 1'b0, 1'b1, acc1, lat);
      store(11'h020, 32'h000000A5, 2'd0, 1'b0, 1'b1, acc1, lat);
      check("byte_latency", lat, 32'd2);
      store(11'h022, 32'h00001234, 2'd1, 1'b0, 1'b1, acc1, lat);
      check("half_latency", lat, 32'd3);
      rd_check("byte_half_rd", 11'h020, 32'hA5661234);

      // Wrap at top of memory
      store(11'h7FE, 32'h11223344, 2'd2, 1'b0, 1'b1, acc1, lat);
      rd_check("wrap_rd", 11'h7FE, 32'h11223344);
      @(negedge clk);
      #2 rd_addr = 11'h000;
      #1 check("wrap_low_half", 32'(rd_data[31:16]), 32'h3344);

      // Back-to-back with req_valid held
      store(11'h100, 32'hA1B2C3D4, 2'd2, 1'b1, 1'b1, acc1, lat);
      store(11'h104, 32'h0BADF00D, 2'd2, 1'b1, 1'b1, acc2, lat);
      store(11'h108, 32'h13579BDF, 2'd2, 1'b0, 1'b1, acc3, lat);
      check("b2b_gap1", acc2 - acc1, 32'd6);
      check("b2b_gap2", acc3 - acc2, 32'd6);
      rd_check("b2b_rd0", 11'h100, 32'hA1B2C3D4);
      rd_check("b2b_rd1", 11'h104, 32'h0BADF00D);
      rd_check("b2b_rd2", 11'h108, 32'h13579BDF);

      // Reset after the second byte of a word store
      store(11'h040, 32'h01020304, 2'd2, 1'b0, 1'b1, acc1, lat);
      store(11'h040, 32'hCAFEF00D, 2'd2, 1'b0, 1'b0, acc1, lat);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_ready", 32'(req_ready), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      rd_check("midrst_rd", 11'h040, 32'hCAFE0304);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (6) @(negedge clk);

      // Misaligned word store
      store(11'h040, 32'hA0A1A2A3, 2'd2, 1'b0, 1'b1, acc1, lat);
      store(11'h044, 32'hB0B1B2B3, 2'd2, 1'b0, 1'b1, acc1, lat);
      store(11'h041, 32'h99887766, 2'd2, 1'b0, 1'b1, acc1, lat);
`ifdef MISALIGN_TRAP_EN
      check("mis_latency", lat, 32'd1);
      check("mis_err", 32'(err), 32'd1);
      rd_check("mis_rd", 11'h041, 32'hA1A2A3B0);
`else
      check("mis_latency", lat, 32'd5);
      check("mis_err", 32'(err), 32'd0);
      rd_check("mis_rd", 11'h041, 32'h99887766);
`endif

      // Random stores with random read address every cycle
      rand_rd = 1'b1;
      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         s = 2'($urandom_range(0, 3));
         a = 11'($urandom);
         d = $urandom;
         exp_lat = trap_of(s, a) ? 1 : nbytes_of(s) + 1;
         store(a, d, s, 1'b0, 1'b1, acc1, lat);
         check("rand_latency", lat, exp_lat);
      end
      rand_rd = 1'b0;
      repeat (4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
